// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 7-segment display front-end.
//   bcd_t      : one BCD digit (4'hF is the blank code understood by seg7)
//   BCD_BLANK  : blank digit code
//   MAX_DEC    : largest value that fits on four decimal digits
//   disp_st_e  : display controller states
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_BLANK = 4'hF;
    localparam int   MAX_DEC   = 9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } disp_st_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one shift/add-3 iteration per cycle.
// A start pulse loads the binary value; W cycles later done pulses for one
// cycle, and during that cycle d3..d0 carry the final BCD result (the result
// of the last iteration, presented combinationally so the caller can
// register it on the same edge that finishes the conversion).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : load bin and begin conversion
//   bin [W-1:0]   : binary value, must be <= 9999
//   done          : one-cycle pulse, final iteration in progress
//   d3..d0        : BCD digits, valid while done = 1 (d3 = thousands)
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         done,
    output bcd_t         d3,
    output bcd_t         d2,
    output bcd_t         d1,
    output bcd_t         d0
);

    localparam int CW = $clog2(W + 1);

    // {bcd[15:0], remaining binary bits}
    logic [W+15:0] r_sh;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic [W+15:0] w_adj;
    logic [W+15:0] w_next;

    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < 4; i++) begin
            if (r_sh[W+4*i +: 4] >= 4'd5) begin
                w_adj[W+4*i +: 4] = r_sh[W+4*i +: 4] + 4'd3;
            end
        end
        w_next = {w_adj[W+14:0], 1'b0};
    end

    assign done = r_busy && (r_cnt == CW'(W - 1));
    assign d3   = w_next[W+12 +: 4];
    assign d2   = w_next[W+8  +: 4];
    assign d1   = w_next[W+4  +: 4];
    assign d0   = w_next[W    +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_sh   <= {16'd0, bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sh  <= w_next;
            r_cnt <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_disp_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_disp_ctrl
// Front-end for the 4-digit 7-seg multiplexer. Arbitrates two requesters
// round-robin, saturates the granted value to 9999, converts it to BCD and
// holds the result on the display for at least HOLD_CYC cycles.
//
//   state | meaning
//   IDLE  | sampling req_i, ack_o driven combinationally on the accept cycle
//   CONV  | double-dabble running (W cycles)
//   HOLD  | display frozen, hold counter counting down to 0
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_i[1:0]        : request levels, bit 0 = A, bit 1 = B
//   val_a_i, val_b_i  : requester values
//   ack_o[1:0]        : one-cycle accept pulse, bit = granted requester
//   busy_o            : high in CONV and HOLD
//   owner_o           : requester of the displayed value
//   ovf_o             : displayed value was saturated
//   d3_o..d0_o        : BCD digits, d3 leftmost, 4'hF = blank
// -----------------------------------------------------------------------------
module seg7_disp_ctrl
    import seg7_pkg::*;
#(
    parameter int W        = 14,
    parameter int HOLD_CYC = 1000000,
    parameter int BLANK_LZ = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_i,
    input  logic [W-1:0] val_a_i,
    input  logic [W-1:0] val_b_i,
    output logic [1:0]   ack_o,
    output logic         busy_o,
    output logic         owner_o,
    output logic         ovf_o,
    output bcd_t         d3_o,
    output bcd_t         d2_o,
    output bcd_t         d1_o,
    output bcd_t         d0_o
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    disp_st_e      r_state;
    disp_st_e      w_state_nxt;
    logic          r_last_grant;
    logic          r_owner_pend;
    logic          r_ovf_pend;
    logic [HW-1:0] r_hold;

    logic          w_gnt_id;
    logic          w_accept;
    logic [W-1:0]  w_sel_val;
    logic          w_ovf_in;
    logic [W-1:0]  w_sat_val;
    logic          w_done;
    bcd_t          w_c3, w_c2, w_c1, w_c0;
    bcd_t          w_b3, w_b2, w_b1;
    logic          w_z3, w_z2, w_z1;

    // Arbiter: on contention the requester that did not win last time goes.
    always_comb begin
        w_gnt_id = 1'b0;
        if (req_i == 2'b10) begin
            w_gnt_id = 1'b1;
        end else if (req_i == 2'b11) begin
            w_gnt_id = ~r_last_grant;
        end
        w_accept  = !rst && (r_state == IDLE) && (req_i != 2'b00);
        ack_o     = 2'b00;
        if (w_accept) begin
            ack_o = w_gnt_id ? 2'b10 : 2'b01;
        end
        w_sel_val = w_gnt_id ? val_b_i : val_a_i;
        w_ovf_in  = (w_sel_val > W'(MAX_DEC));
        w_sat_val = w_ovf_in ? W'(MAX_DEC) : w_sel_val;
    end

    // The converter's shift register acts as the latch for the accepted value.
    bin2bcd_seq #(
        .W (W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .bin   (w_sat_val),
        .done  (w_done),
        .d3    (w_c3),
        .d2    (w_c2),
        .d1    (w_c1),
        .d0    (w_c0)
    );

    // Leading-zero blanking cascades from the left; d0 always shows.
    always_comb begin
        w_z3 = (w_c3 == 4'd0);
        w_z2 = w_z3 && (w_c2 == 4'd0);
        w_z1 = w_z2 && (w_c1 == 4'd0);
        w_b3 = w_c3;
        w_b2 = w_c2;
        w_b1 = w_c1;
        if (BLANK_LZ != 0) begin
            if (w_z3) w_b3 = BCD_BLANK;
            if (w_z2) w_b2 = BCD_BLANK;
            if (w_z1) w_b1 = BCD_BLANK;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)             w_state_nxt = CONV;
            CONV:    if (w_done)               w_state_nxt = HOLD;
            HOLD:    if (r_hold == HW'(0))     w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner_pend <= 1'b0;
            r_ovf_pend   <= 1'b0;
            r_hold       <= '0;
            owner_o      <= 1'b0;
            ovf_o        <= 1'b0;
            d3_o         <= BCD_BLANK;
            d2_o         <= BCD_BLANK;
            d1_o         <= BCD_BLANK;
            d0_o         <= BCD_BLANK;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt_id;
                r_owner_pend <= w_gnt_id;
                r_ovf_pend   <= w_ovf_in;
            end
            if ((r_state == CONV) && w_done) begin
                d3_o    <= w_b3;
                d2_o    <= w_b2;
                d1_o    <= w_b1;
                d0_o    <= w_c0;
                owner_o <= r_owner_pend;
                ovf_o   <= r_ovf_pend;
                r_hold  <= HW'(HOLD_CYC - 1);
            end else if ((r_state == HOLD) && (r_hold != HW'(0))) begin
                r_hold <= r_hold - HW'(1);
            end
        end
    end

    assign busy_o = (r_state != IDLE);

endmodule
